// File: rtl/decoder_pkg.sv
// Shared constants, FSM state type and 5-to-32 decoder helpers for the priority encoder.
package decoder_pkg;
  localparam int LINES     = 32;
  localparam int IDX_W     = 5;
  localparam int DEC_IN_W  = 5;
  localparam int DEC_OUT_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  function automatic logic [DEC_OUT_W-1:0] onehot(input logic [DEC_IN_W-1:0] sel);
    logic [DEC_OUT_W-1:0] v;
    v = '0;
    v[sel] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/prio_find32.sv
// Combinational search for the first set bit of vec, scanning upward from start
// and wrapping at the top. With start = 0 this is plain lowest-bit-wins priority.
module prio_find32 #(
  parameter int LINES = 32,
  parameter int IDX_W = 5
) (
  input  logic [LINES-1:0] vec,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] index
);
  logic [IDX_W-1:0] k;

  // Scan offsets from high to low so the smallest offset from start is the last hit.
  always_comb begin
    index = '0;
    k     = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      k = start + IDX_W'(i);
      if (vec[k]) index = k;
    end
  end

  assign found = |vec;
endmodule

// File: rtl/priority_encoder32x5.sv
// Registered priority encoder with a pending register and a valid/ready offer stage.
// Define ROTATING_PRIORITY_EN to search round-robin from the last accepted index + 1.
module priority_encoder32x5
  import decoder_pkg::*;
#(
  parameter int LINES = decoder_pkg::LINES,
  parameter int IDX_W = decoder_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [LINES-1:0] req_n,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  input  logic             ready,
  output logic             any_n,
  output state_t           state
);
  // Handshake: idx is offered while valid is high; it is consumed at a rising
  // edge where valid and ready are both high, and idx/valid never change while
  // an offer is waiting for ready.
  logic [LINES-1:0] pending;
  logic [LINES-1:0] set_vec;
  logic [LINES-1:0] clr_vec;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             accept;

  assign accept = (state == OFFER) && ready;

  always_comb begin
    set_vec = en ? ~req_n : '0;
    clr_vec = '0;
    if (accept) clr_vec[idx] = 1'b1;
  end

  // A line requesting in its own acceptance cycle stays pending (set wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_vec) | set_vec;
  end

  assign any_n = ~|pending;

`ifdef ROTATING_PRIORITY_EN
  logic [IDX_W-1:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= '0;
    else if (accept) ptr <= idx + 1'b1;
  end

  assign start = ptr;
`else
  assign start = '0;
`endif

  prio_find32 #(.LINES(LINES), .IDX_W(IDX_W)) u_find (
    .vec   (pending),
    .start (start),
    .found (sel_found),
    .index (sel_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            idx   <= sel_idx;
            valid <= 1'b1;
            state <= OFFER;
          end
        end
        OFFER: begin
          if (ready) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
